id_ex_stage: RTL and testbench

//  ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RV32 core.

---
 rtl/id_ex_stage.sv | 120 ++++++++++++
 tb/tb_id_ex_stage.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection; ID fields appear on EX outputs 1 cycle after capture.
// Stall_i freezes the whole stage; a flush or load-use hazard loads an all-zero bubble instead of the ID fields.
module id_ex_stage #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 2,
    parameter int FUNCT_W = 10
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               Stall_i,
    input  logic               Flush_i,
    input  logic [XLEN-1:0]    RS1data_i,
    input  logic [XLEN-1:0]    RS2data_i,
    input  logic [XLEN-1:0]    Imm_i,
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic [REG_AW-1:0]  Rs1_i,
    input  logic [REG_AW-1:0]  Rs2_i,
    input  logic [REG_AW-1:0]  Rd_i,
    input  logic               RegWrite_i,
    input  logic               MemtoReg_i,
    input  logic               MemRead_i,
    input  logic               MemWrite_i,
    input  logic               ALUSrc_i,
    input  logic [ALUOP_W-1:0] ALUOp_i,
    output logic [XLEN-1:0]    EXRS1data_o,
    output logic [XLEN-1:0]    EXRS2data_o,
    output logic [XLEN-1:0]    EXImm_o,
    output logic [FUNCT_W-1:0] EXfunct_o,
    output logic [REG_AW-1:0]  EXRs1_o,
    output logic [REG_AW-1:0]  EXRs2_o,
    output logic [REG_AW-1:0]  EXRd_o,
    output logic               EXRegWrite_o,
    output logic               EXMemtoReg_o,
    output logic               EXMemRead_o,
    output logic               EXMemWrite_o,
    output logic               EXALUSrc_o,
    output logic [ALUOP_W-1:0] EXALUOp_o,
    output logic               EXValid_o,
    output logic               NoOp_o,
    output logic               PCWrite_o,
    output logic               IFIDStall_o
);

    typedef struct packed {
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic [FUNCT_W-1:0] funct;
        logic [REG_AW-1:0]  rs1;
        logic [REG_AW-1:0]  rs2;
        logic [REG_AW-1:0]  rd;
        logic               reg_write;
        logic               mem_to_reg;
        logic               mem_read;
        logic               mem_write;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic               valid;
    } ex_t;

    ex_t  ex_q;
    ex_t  id_pkt;
    logic hazard;

    always_comb begin
        id_pkt            = '0;
        id_pkt.rs1_data   = RS1data_i;
        id_pkt.rs2_data   = RS2data_i;
        id_pkt.imm        = Imm_i;
        id_pkt.funct      = funct_i;
        id_pkt.rs1        = Rs1_i;
        id_pkt.rs2        = Rs2_i;
        id_pkt.rd         = Rd_i;
        id_pkt.reg_write  = RegWrite_i;
        id_pkt.mem_to_reg = MemtoReg_i;
        id_pkt.mem_read   = MemRead_i;
        id_pkt.mem_write  = MemWrite_i;
        id_pkt.alu_src    = ALUSrc_i;
        id_pkt.alu_op     = ALUOp_i;
        id_pkt.valid      = 1'b1;
    end

    // rs2 is compared even for formats without rs2; the occasional spurious stall is harmless.
    assign hazard = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
                    ((ex_q.rd == Rs1_i) | (ex_q.rd == Rs2_i));

    // A bubble is all-zero so register indices can never match in the forwarding unit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q <= '0;
        end else if (!Stall_i) begin
            if (Flush_i || hazard) begin
                ex_q <= '0;
            end else begin
                ex_q <= id_pkt;
            end
        end
    end

    assign EXRS1data_o  = ex_q.rs1_data;
    assign EXRS2data_o  = ex_q.rs2_data;
    assign EXImm_o      = ex_q.imm;
    assign EXfunct_o    = ex_q.funct;
    assign EXRs1_o      = ex_q.rs1;
    assign EXRs2_o      = ex_q.rs2;
    assign EXRd_o       = ex_q.rd;
    assign EXRegWrite_o = ex_q.reg_write;
    assign EXMemtoReg_o = ex_q.mem_to_reg;
    assign EXMemRead_o  = ex_q.mem_read;
    assign EXMemWrite_o = ex_q.mem_write;
    assign EXALUSrc_o   = ex_q.alu_src;
    assign EXALUOp_o    = ex_q.alu_op;
    assign EXValid_o    = ex_q.valid;

    assign NoOp_o      = hazard;
    assign IFIDStall_o = hazard;
    assign PCWrite_o   = ~hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: capture, load-use bubble, x0 load, flush, stall priority, async reset.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        Stall_i, Flush_i;
    logic [31:0] RS1data_i, RS2data_i, Imm_i;
    logic [9:0]  funct_i;
    logic [4:0]  Rs1_i, Rs2_i, Rd_i;
    logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i;
    logic [1:0]  ALUOp_i;
    logic [31:0] EXRS1data_o, EXRS2data_o, EXImm_o;
    logic [9:0]  EXfunct_o;
    logic [4:0]  EXRs1_o, EXRs2_o, EXRd_o;
    logic        EXRegWrite_o, EXMemtoReg_o, EXMemRead_o, EXMemWrite_o, EXALUSrc_o;
    logic [1:0]  EXALUOp_o;
    logic        EXValid_o, NoOp_o, PCWrite_o, IFIDStall_o;

    int n_vec = 0;
    int n_bad = 0;

    id_ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .Stall_i(Stall_i), .Flush_i(Flush_i),
        .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i), .funct_i(funct_i),
        .Rs1_i(Rs1_i), .Rs2_i(Rs2_i), .Rd_i(Rd_i),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i),
        .EXRS1data_o(EXRS1data_o), .EXRS2data_o(EXRS2data_o), .EXImm_o(EXImm_o),
        .EXfunct_o(EXfunct_o), .EXRs1_o(EXRs1_o), .EXRs2_o(EXRs2_o), .EXRd_o(EXRd_o),
        .EXRegWrite_o(EXRegWrite_o), .EXMemtoReg_o(EXMemtoReg_o), .EXMemRead_o(EXMemRead_o),
        .EXMemWrite_o(EXMemWrite_o), .EXALUSrc_o(EXALUSrc_o), .EXALUOp_o(EXALUOp_o),
        .EXValid_o(EXValid_o), .NoOp_o(NoOp_o), .PCWrite_o(PCWrite_o), .IFIDStall_o(IFIDStall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_id();
        RS1data_i = '0; RS2data_i = '0; Imm_i = '0; funct_i = '0;
        Rs1_i = '0; Rs2_i = '0; Rd_i = '0;
        RegWrite_i = 0; MemtoReg_i = 0; MemRead_i = 0; MemWrite_i = 0; ALUSrc_i = 0;
        ALUOp_i = '0;
    endtask

    initial begin
        rst_i = 0; Stall_i = 0; Flush_i = 0;
        clear_id();
        tick(); tick();
        chk("rst_valid",   32'(EXValid_o), 0);
        chk("rst_regwr",   32'(EXRegWrite_o), 0);
        chk("rst_pcwrite", 32'(PCWrite_o), 1);
        rst_i = 1;

        // capture
        Rs1_i = 3; Rs2_i = 4; Rd_i = 5; RS1data_i = 32'h1234; RS2data_i = 32'h55AA;
        Imm_i = 32'hFFFF_FFF0; funct_i = 10'h207; RegWrite_i = 1; ALUOp_i = 2'b10;
        tick();
        chk("cap_rs1",   32'(EXRs1_o), 3);
        chk("cap_rs2",   32'(EXRs2_o), 4);
        chk("cap_rd",    32'(EXRd_o), 5);
        chk("cap_d1",    EXRS1data_o, 32'h1234);
        chk("cap_d2",    EXRS2data_o, 32'h55AA);
        chk("cap_imm",   EXImm_o, 32'hFFFF_FFF0);
        chk("cap_funct", 32'(EXfunct_o), 32'h207);
        chk("cap_aluop", 32'(EXALUOp_o), 2);
        chk("cap_regwr", 32'(EXRegWrite_o), 1);
        chk("cap_valid", 32'(EXValid_o), 1);
        chk("cap_noop",  32'(NoOp_o), 0);

        // load-use: lw x5,8(x1) then add x6,x5,x1
        clear_id();
        Rs1_i = 1; Rd_i = 5; Imm_i = 8; RegWrite_i = 1; MemtoReg_i = 1; MemRead_i = 1; ALUSrc_i = 1;
        tick();
        chk("lw_memrd", 32'(EXMemRead_o), 1);
        clear_id();
        Rs1_i = 5; Rs2_i = 1; Rd_i = 6; RegWrite_i = 1; RS2data_i = 32'h77;
        #1;
        chk("lu_noop",    32'(NoOp_o), 1);
        chk("lu_pcwrite", 32'(PCWrite_o), 0);
        chk("lu_ifid",    32'(IFIDStall_o), 1);
        tick();
        chk("lu_bub_rd",    32'(EXRd_o), 0);
        chk("lu_bub_valid", 32'(EXValid_o), 0);
        chk("lu_bub_memrd", 32'(EXMemRead_o), 0);
        chk("lu_bub_regwr", 32'(EXRegWrite_o), 0);
        chk("lu_bub_noop",  32'(NoOp_o), 0);
        tick();
        chk("lu_add_rd",    32'(EXRd_o), 6);
        chk("lu_add_rs1",   32'(EXRs1_o), 5);
        chk("lu_add_d2",    EXRS2data_o, 32'h77);
        chk("lu_add_valid", 32'(EXValid_o), 1);

        // load to x0 never stalls
        clear_id();
        Rs1_i = 2; Rd_i = 0; MemRead_i = 1; RegWrite_i = 1; MemtoReg_i = 1;
        tick();
        clear_id();
        Rs1_i = 0; Rs2_i = 0; Rd_i = 7; RegWrite_i = 1;
        #1;
        chk("x0_noop", 32'(NoOp_o), 0);
        tick();
        chk("x0_rd",    32'(EXRd_o), 7);
        chk("x0_valid", 32'(EXValid_o), 1);

        // flush
        clear_id();
        Rs1_i = 8; Rd_i = 9; RegWrite_i = 1; MemWrite_i = 1; RS1data_i = 32'hDEAD;
        Flush_i = 1;
        tick();
        Flush_i = 0;
        chk("fl_valid", 32'(EXValid_o), 0);
        chk("fl_regwr", 32'(EXRegWrite_o), 0);
        chk("fl_memwr", 32'(EXMemWrite_o), 0);
        chk("fl_rd",    32'(EXRd_o), 0);
        chk("fl_d1",    EXRS1data_o, 0);

        // stall beats flush and hazard; hazard via rs2
        clear_id();
        Rs1_i = 11; Rd_i = 10; RS1data_i = 32'hABCD; MemRead_i = 1; RegWrite_i = 1;
        tick();
        clear_id();
        Rs1_i = 3; Rs2_i = 10; Rd_i = 12; RegWrite_i = 1;
        Stall_i = 1; Flush_i = 1;
        #1;
        chk("st_noop", 32'(NoOp_o), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("st_rd%0d", i),    32'(EXRd_o), 10);
            chk($sformatf("st_d1%0d", i),    EXRS1data_o, 32'hABCD);
            chk($sformatf("st_valid%0d", i), 32'(EXValid_o), 1);
            chk($sformatf("st_memrd%0d", i), 32'(EXMemRead_o), 1);
        end
        Stall_i = 0;
        tick();
        chk("st_bub_valid", 32'(EXValid_o), 0);
        chk("st_bub_rd",    32'(EXRd_o), 0);
        Flush_i = 0;
        tick();
        chk("st_cap_rd",    32'(EXRd_o), 12);
        chk("st_cap_rs2",   32'(EXRs2_o), 10);
        chk("st_cap_valid", 32'(EXValid_o), 1);
        chk("st_cap_regwr", 32'(EXRegWrite_o), 1);

        // asynchronous reset mid-cycle
        #2;
        rst_i = 0;
        #1;
        chk("ar_regwr", 32'(EXRegWrite_o), 0);
        chk("ar_valid", 32'(EXValid_o), 0);
        chk("ar_rd",    32'(EXRd_o), 0);
        chk("ar_rs2",   32'(EXRs2_o), 0);
        tick();
        chk("ar_hold_valid", 32'(EXValid_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
